// File: rtl/vliw_regfile_sb_pkg.sv
// vliw_regfile_sb_pkg: shared defaults, address-width helper and issue-slot enum
package vliw_regfile_sb_pkg;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_NUM_RD   = 4;
  localparam int DEF_NUM_WR   = 2;
  typedef enum logic {SLOT_32 = 1'b0, SLOT_16 = 1'b1} slot_e;
  function automatic int calc_aw(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/vliw_regfile_sb_scoreboard.sv
// regfile_scoreboard: per-register busy bits, issue arbitration and writeback clear
module regfile_scoreboard
  import vliw_regfile_sb_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter int AW       = calc_aw(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic [NUM_WR-1:0]    iss_en,
  input  logic [NUM_WR*AW-1:0] iss_rd,
  output logic [NUM_WR-1:0]    iss_ack,
  output logic [NUM_REGS-1:0]  busy
);
  logic [NUM_REGS-1:0] busy_q, busy_d;
  // a lower slot targeting the same register always wins the reservation
  always_comb begin
    iss_ack = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      iss_ack[i] = reset && iss_en[i] && !busy_q[iss_rd[i*AW +: AW]];
      for (int j = 0; j < i; j++)
        if (iss_en[j] && iss_rd[j*AW +: AW] == iss_rd[i*AW +: AW]) iss_ack[i] = 1'b0;
    end
  end
  // clears first, then sets, so a same-cycle issue keeps the register busy
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_WR; i++)
      if (wr_en[i]) busy_d[wr_addr[i*AW +: AW]] = 1'b0;
    for (int i = 0; i < NUM_WR; i++)
      if (iss_ack[i]) busy_d[iss_rd[i*AW +: AW]] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  assign busy = busy_q;
endmodule

// File: rtl/vliw_regfile_sb.sv
// vliw_regfile_sb: multi-port VLIW register file with issue scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writebacks to the read ports.
module vliw_regfile_sb
  import vliw_regfile_sb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter int AW       = calc_aw(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR-1:0]        iss_en,
  input  logic [NUM_WR*AW-1:0]     iss_rd,
  output logic [NUM_WR-1:0]        iss_ack,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     wr_collision
);
  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [DATA_W-1:0]   mem_d [NUM_REGS];
  logic                wr_collision_q, wr_collision_d;
  logic [NUM_REGS-1:0] busy;

  regfile_scoreboard #(.NUM_REGS(NUM_REGS), .NUM_WR(NUM_WR), .AW(AW)) u_sb (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .iss_en  (iss_en),
    .iss_rd  (iss_rd),
    .iss_ack (iss_ack),
    .busy    (busy)
  );

  // highest slot written first so the lowest colliding slot lands last
  always_comb begin
    mem_d = mem_q;
    wr_collision_d = 1'b0;
    for (int i = NUM_WR - 1; i >= 0; i--)
      if (wr_en[i] && wr_addr[i*AW +: AW] != '0)
        mem_d[wr_addr[i*AW +: AW]] = wr_data[i*DATA_W +: DATA_W];
    for (int i = 0; i < NUM_WR; i++)
      for (int j = 0; j < i; j++)
        if (wr_en[i] && wr_en[j] && wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW])
          wr_collision_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mem_q          <= '{default: '0};
      wr_collision_q <= 1'b0;
    end else begin
      mem_q          <= mem_d;
      wr_collision_q <= wr_collision_d;
    end

  assign wr_collision = wr_collision_q;

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data[p*DATA_W +: DATA_W] = (!reset || rd_addr[p*AW +: AW] == '0) ? '0
                                                                           : mem_q[rd_addr[p*AW +: AW]];
      rd_busy[p] = busy[rd_addr[p*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int i = NUM_WR - 1; i >= 0; i--)
        if (reset && wr_en[i] && rd_addr[p*AW +: AW] != '0 &&
            wr_addr[i*AW +: AW] == rd_addr[p*AW +: AW]) begin
          rd_data[p*DATA_W +: DATA_W] = wr_data[i*DATA_W +: DATA_W];
          rd_busy[p] = 1'b0;
        end
`endif
    end
  end
endmodule

// File: doc/vliw_regfile_sb.md
VLIW_REGFILE_SB -- requirements
Module: vliw_regfile_sb

Interface
REQ-001 SHALL have parameters, one per line:
- DATA_W, 32, register width.
- NUM_REGS, 32, register count (power of 2, >=4).
- NUM_RD, 4, read ports.
- NUM_WR, 2, write/issue slots (slot 0 = 32-bit slot, slot 1 = 16-bit slot).
- AW = log2(NUM_REGS), derived.
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  NUM_WR  writeback valid per slot.
- wr_addr  in  NUM_WR*AW  writeback destination per slot.
- wr_data  in  NUM_WR*DATA_W  writeback data per slot.
- iss_en  in  NUM_WR  issue request per slot; reserves a destination.
- iss_rd  in  NUM_WR*AW  destination to reserve per slot.
- iss_ack  out  NUM_WR  issue accepted this cycle (combinational).
- rd_addr  in  NUM_RD*AW  read address per port.
- rd_data  out  NUM_RD*DATA_W  read data per port (combinational).
- rd_busy  out  NUM_RD  addressed register has a pending producer.
- wr_collision  out  1  registered flag: previous cycle had two enabled writebacks to the same address.

Function
REQ-003 SHALL hold NUM_REGS x DATA_W storage plus NUM_REGS busy bits (scoreboard).
REQ-004 SHALL write wr_data into wr_addr on the rising clk when wr_en is set; the write latency is one cycle.
REQ-005 On equal wr_addr with both slots enabled, SHALL write the lowest-index slot only and set wr_collision high for exactly the following cycle.
REQ-006 SHALL clear busy[wr_addr] on every enabled writeback.
REQ-007 SHALL assert iss_ack[i] when iss_en[i]=1, busy[iss_rd[i]]=0, and no lower-index slot is issuing to the same iss_rd; otherwise iss_ack[i]=0.
REQ-008 SHALL set busy[iss_rd[i]] on the rising clk when iss_ack[i]=1.
REQ-009 When the same register is both issued and written back in one cycle, the set SHALL win (busy stays 1) and the data SHALL still be written.
REQ-010 SHALL drive rd_data[p] from storage[rd_addr[p]] and rd_busy[p]=busy[rd_addr[p]], subject to REQ-011 and REQ-016.
REQ-011 Register 0 SHALL always read 0 and never go busy; writes and issues to 0 SHALL be ignored, and iss_ack SHALL still be asserted for them.
REQ-012 Reads SHALL see storage as of the start of the current cycle unless the feature in REQ-016 is compiled in.

Reset
REQ-013 reset low SHALL asynchronously clear all storage, all busy bits and wr_collision.
REQ-014 While reset is low, iss_ack SHALL be 0 and rd_data SHALL be 0; no write or issue SHALL take effect.
REQ-015 A reset asserted mid-operation SHALL discard all pending reservations; after release, the first rising edge SHALL behave as normal operation.

Configuration
REQ-016 With REGFILE_BYPASS_EN defined:
- an enabled same-cycle writeback to rd_addr[p] SHALL forward wr_data to rd_data[p], using the lowest-index slot per REQ-005.
- rd_busy[p] SHALL be 0 for that port.
REQ-017 Without REGFILE_BYPASS_EN, there SHALL be no forwarding path, and behaviour SHALL be per REQ-012.

Structure
REQ-018 A shared package SHALL hold:
- the default DATA_W, NUM_REGS, NUM_RD and NUM_WR constants;
- the AW function;
- a slot-index enum (SLOT_32=0, SLOT_16=1).
REQ-019 The scoreboard SHALL be one sub-module, regfile_scoreboard, containing the busy bits, the issue arbitration and the clear logic; storage and read muxing SHALL stay in the top module.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then read all registers -> all 0; rd_busy=0; iss_ack=0 during reset.
- Slot0 writes r5=0xDEADBEEF -> next cycle, rd_addr=5 returns 0xDEADBEEF; with bypass, the same cycle returns it.
- Both slots write r7 (0x11 and 0x22) -> r7=0x11; wr_collision=1 for exactly one cycle.
- Issue r3 on both slots -> iss_ack=2'b01; busy[3]=1; a re-issue of r3 next cycle gets ack 0 until writeback.
- Same cycle: issue r9 and writeback r9=0x55 -> busy[9]=1 and r9=0x55.
- Write/issue r0 with 0xFFFF -> r0 reads 0; rd_busy=0; iss_ack=1.
- Reset pulsed with r4 busy -> busy cleared; r4=0.
